// File: rtl/gift64_round_ctrl.sv
// gift64_round_ctrl: iterative round sequencer for the GIFT-64 datapath.
// Issues load strobes, walks round index/constant forward or backward, then holds a completion handshake.
module gift64_round_ctrl #(
    parameter int unsigned ROUNDS  = 28,
    parameter logic [5:0]  RC_INIT = 6'h01,
    parameter logic [5:0]  RC_LAST = 6'h0B,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_dec,
    output logic             in_ready,
    input  logic             abort,
    output logic             ld_state,
    output logic             ld_key,
    output logic             rnd_en,
    output logic             dec,
    output logic [5:0]       round_idx,
    output logic [5:0]       round_const,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt
);
    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

    localparam logic [5:0]       IDX_LAST = 6'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic             ld_q, ld_d, rnd_en_q, rnd_en_d, dec_q, dec_d;
    logic             out_valid_q, out_valid_d, busy_q, busy_d;
    logic [5:0]       idx_q, idx_d, rc_q, rc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last;

    assign in_ready    = (state_q == IDLE) & ~rst;
    assign last        = dec_q ? (idx_q == 6'd0) : (idx_q == IDX_LAST);
    assign ld_state    = ld_q;
    assign ld_key      = ld_q;
    assign rnd_en      = rnd_en_q;
    assign dec         = dec_q;
    assign round_idx   = idx_q;
    assign round_const = rc_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign blk_cnt     = cnt_q;

    // Round 0 values are preset at accept so they are already visible during LOAD.
    always_comb begin
        state_d     = state_q;
        ld_d        = 1'b0;
        rnd_en_d    = 1'b0;
        dec_d       = dec_q;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        idx_d       = idx_q;
        rc_d        = rc_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = LOAD;
                    ld_d    = 1'b1;
                    busy_d  = 1'b1;
                    dec_d   = in_dec;
                    idx_d   = in_dec ? IDX_LAST : 6'd0;
                    rc_d    = in_dec ? RC_LAST : RC_INIT;
                end
            end
            LOAD: begin
                state_d  = abort ? IDLE : ROUND;
                rnd_en_d = ~abort;
                busy_d   = ~abort;
            end
            ROUND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    rnd_en_d = 1'b1;
                    busy_d   = 1'b1;
                    idx_d    = dec_q ? idx_q - 6'd1 : idx_q + 6'd1;
                    rc_d     = dec_q ? {rc_q[0] ^ rc_q[5] ^ 1'b1, rc_q[5:1]}
                                     : {rc_q[4:0], rc_q[5] ^ rc_q[4] ^ 1'b1};
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + CNT_ONE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ld_q        <= 1'b0;
            rnd_en_q    <= 1'b0;
            dec_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            idx_q       <= 6'd0;
            rc_q        <= 6'd0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ld_q        <= ld_d;
            rnd_en_q    <= rnd_en_d;
            dec_q       <= dec_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            idx_q       <= idx_d;
            rc_q        <= rc_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule
